// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   RV_XLEN      default address/instruction width
//   RV_NOP       canonical RISC-V no-op (addi x0,x0,0), for decode bubbles
//   rsp_kind_e   what to do with a memory response this cycle
//   classify_rsp helper that maps rvalid/flush/drain state to rsp_kind_e
package if_fetch_queue_pkg;

  localparam int          RV_XLEN = 32;
  localparam logic [31:0] RV_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    RSP_NONE,  // no response this cycle
    RSP_DROP,  // response belongs to a fetch squashed by a flush
    RSP_FILL   // response completes the oldest unfilled entry
  } rsp_kind_e;

  // A response is discarded when it arrives during a flush or while older
  // squashed fetches are still draining out of memory.
  function automatic rsp_kind_e classify_rsp(input logic rvalid,
                                             input logic flush,
                                             input logic draining);
    if (!rvalid) return RSP_NONE;
    if (flush || draining) return RSP_DROP;
    return RSP_FILL;
  endfunction

endpackage

// File: rtl/if_queue_mem.sv
// Storage for the fetch queue: DEPTH entries of {pc, instr}.
//   clk, reset            clock, synchronous active-high reset
//   alloc_en/idx/pc       write PC of a newly granted fetch
//   fill_en/idx/instr     write the returned instruction word
//   head_idx              read index (oldest entry)
//   head_pc, head_instr   asynchronous read of the head entry
module if_queue_mem
  import if_fetch_queue_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [PTR_W-1:0] alloc_idx,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             fill_en,
  input  logic [PTR_W-1:0] fill_idx,
  input  logic [XLEN-1:0]  fill_instr,
  input  logic [PTR_W-1:0] head_idx,
  output logic [XLEN-1:0]  head_pc,
  output logic [XLEN-1:0]  head_instr
);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  // NOTE: the array is reset on purpose: it is only DEPTH flops deep and the
  // head entry drives id_pc/id_instr, which must read zero after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (alloc_en) pc_mem[alloc_idx]   <= alloc_pc;
      if (fill_en)  instr_mem[fill_idx] <= fill_instr;
    end
  end

  assign head_pc    = pc_mem[head_idx];
  assign head_instr = instr_mem[head_idx];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage between the PC register and decode.
//   clk, reset          clock, synchronous active-high reset
//   pc                  current PC (PC.dataout)
//   pc_enable           advances the PC; high exactly when a fetch is granted
//   flush               redirect: squash queued entries and in-flight fetches
//   imem_req/addr/gnt   in-order request channel to instruction memory
//   imem_rvalid/rdata   in-order response channel, >=1 cycle after grant
//   id_valid/pc/instr   head entry presented to decode
//   id_ready            decode accepts the head entry
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_enable,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_ptr, alloc_ptr, fill_ptr;
  logic [CNT_W-1:0] count, drop_cnt;
  logic [DEPTH-1:0] filled;
  logic [CNT_W-1:0] filled_cnt, unfilled_cnt;
  logic             grant, pop, fill_en;
  rsp_kind_e        rsp_kind;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) filled_cnt = filled_cnt + CNT_W'(filled[i]);
  end

  // Fetches granted but not yet answered; on a flush these become drops.
  assign unfilled_cnt = count - filled_cnt;

  // Issue depends only on registered state, never on id_ready, so a pop in
  // this cycle does not open a slot until the next one.
  assign imem_req  = !reset && !flush && (count < CNT_W'(DEPTH)) && (drop_cnt == '0);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign pc_enable = grant;

  assign id_valid = filled[head_ptr] && !flush;
  assign pop      = id_valid && id_ready;

  assign rsp_kind = classify_rsp(imem_rvalid, flush, drop_cnt != '0);
  assign fill_en  = (rsp_kind == RSP_FILL);

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
    end else if (flush) begin
      count     <= '0;
      filled    <= '0;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      // The response arriving now is dropped in place, so it leaves the tally.
      drop_cnt  <= drop_cnt + unfilled_cnt - CNT_W'(imem_rvalid);
    end else begin
      if (grant)   alloc_ptr <= alloc_ptr + PTR_W'(1);
      if (fill_en) fill_ptr  <= fill_ptr + PTR_W'(1);
      if (pop)     head_ptr  <= head_ptr + PTR_W'(1);
      if (rsp_kind == RSP_DROP) drop_cnt <= drop_cnt - CNT_W'(1);

      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase

      // Fill targets an unfilled entry and pop a filled one, so they never
      // collide; a newly allocated slot is already clear from its last pop.
      for (int i = 0; i < DEPTH; i++) begin
        if (fill_en && fill_ptr == PTR_W'(i))     filled[i] <= 1'b1;
        else if (pop && head_ptr == PTR_W'(i))    filled[i] <= 1'b0;
      end
    end
  end

  if_queue_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (grant),
    .alloc_idx  (alloc_ptr),
    .alloc_pc   (pc),
    .fill_en    (fill_en),
    .fill_idx   (fill_ptr),
    .fill_instr (imem_rdata),
    .head_idx   (head_ptr),
    .head_pc    (id_pc),
    .head_instr (id_instr)
  );

  // A response with nothing outstanding and nothing to drain means memory
  // answered a fetch that was never granted.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && drop_cnt == '0 && unfilled_cnt == '0));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue. The bench plays the PC register (reset
// to 0, +4 on pc_enable, load on redirect) and an in-order memory that answers
// granted fetches when told to. Expected outputs per cycle are hand-computed.
`timescale 1ns/1ps
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int XLEN  = RV_XLEN;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset, flush, imem_gnt, imem_rvalid, id_ready;
  logic            pc_enable, imem_req, id_valid;
  logic [XLEN-1:0] pc, imem_addr, imem_rdata, id_pc, id_instr;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [XLEN-1:0] oq[$];          // granted, not yet answered by memory
  logic [XLEN-1:0] redirect_pc;

  always #5 clk = ~clk;

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_enable   (pc_enable),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_ready    (id_ready)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return RV_NOP ^ (a << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge: apply this cycle's inputs, settle mid-cycle.
  task automatic drive(input logic rst, input logic gnt, input logic rsp,
                       input logic rdy, input logic fl);
    reset       = rst;
    imem_gnt    = gnt;
    id_ready    = rdy;
    flush       = fl;
    imem_rvalid = rsp && (oq.size() != 0);
    imem_rdata  = imem_rvalid ? instr_of(oq[0]) : '0;
    @(negedge clk);
  endtask

  // Cross the next posedge, updating the PC model and the memory model.
  task automatic advance();
    logic g, r, rst, fl;
    logic [31:0] a;
    g = pc_enable; r = imem_rvalid; rst = reset; fl = flush; a = imem_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      pc = '0;
      oq.delete();
    end else begin
      if (fl)     pc = redirect_pc;
      else if (g) pc = pc + 32'd4;
      if (r) void'(oq.pop_front());
      if (g) oq.push_back(a);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ipc);
    chk({tag, " imem_req"},  32'(imem_req),  32'(req));
    chk({tag, " pc_enable"}, 32'(pc_enable), 32'(req & imem_gnt));
    chk({tag, " imem_addr"}, imem_addr,      addr);
    chk({tag, " id_valid"},  32'(id_valid),  32'(vld));
    if (vld) begin
      chk({tag, " id_pc"},    id_pc,    ipc);
      chk({tag, " id_instr"}, id_instr, instr_of(ipc));
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic gnt, input logic rsp,
                      input logic rdy, input logic fl, input logic req,
                      input logic [31:0] addr, input logic vld, input logic [31:0] ipc);
    drive(rst, gnt, rsp, rdy, fl);
    expect_out(tag, req, addr, vld, ipc);
    advance();
  endtask

  // Two reset cycles with grant held high; outputs must stay quiet.
  task automatic do_reset(input string tag);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk({tag, " c1 imem_req"},  32'(imem_req),  32'd0);
    chk({tag, " c1 pc_enable"}, 32'(pc_enable), 32'd0);
    advance();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk({tag, " c2 imem_req"},  32'(imem_req),  32'd0);
    chk({tag, " c2 pc_enable"}, 32'(pc_enable), 32'd0);
    chk({tag, " c2 id_valid"},  32'(id_valid),  32'd0);
    chk({tag, " c2 id_pc"},     id_pc,          32'd0);
    chk({tag, " c2 id_instr"},  id_instr,       32'd0);
    chk({tag, " count"},        32'(dut.count),    32'd0);
    chk({tag, " drop_cnt"},     32'(dut.drop_cnt), 32'd0);
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    imem_rdata = '0; id_ready = 1'b1; pc = '0; redirect_pc = '0;
    @(posedge clk);
    #1;

    // 1: reset, then first request at address 0
    do_reset("rst");
    step("rst_rel", 0, 1, 0, 1, 0, 1, 32'h0, 0, 32'h0);

    // 2: streaming, one-cycle memory latency, decode always ready
    step("s1", 0, 1, 1, 1, 0, 1, 32'h4,  0, 32'h0);
    step("s2", 0, 1, 1, 1, 0, 0, 32'h8,  1, 32'h0);
    step("s3", 0, 1, 1, 1, 0, 1, 32'h8,  1, 32'h4);
    step("s4", 0, 1, 1, 1, 0, 1, 32'hC,  0, 32'h0);
    step("s5", 0, 1, 1, 1, 0, 0, 32'h10, 1, 32'h8);
    step("s6", 0, 1, 1, 1, 0, 1, 32'h10, 1, 32'hC);

    // 3: backpressure fills the queue and stalls the PC at 8
    do_reset("rst_b");
    step("b0", 0, 1, 1, 0, 0, 1, 32'h0, 0, 32'h0);
    step("b1", 0, 1, 1, 0, 0, 1, 32'h4, 0, 32'h0);
    step("b2", 0, 1, 1, 0, 0, 0, 32'h8, 1, 32'h0);
    step("b3", 0, 1, 1, 0, 0, 0, 32'h8, 1, 32'h0);
    step("b4", 0, 0, 1, 1, 0, 0, 32'h8, 1, 32'h0);
    step("b5", 0, 0, 1, 1, 0, 1, 32'h8, 1, 32'h4);
    step("b6", 0, 0, 1, 1, 0, 1, 32'h8, 0, 32'h0);

    // 4: flush with two fetches in flight, redirect to 0x100
    do_reset("rst_f");
    redirect_pc = 32'h100;
    step("f0", 0, 1, 0, 1, 0, 1, 32'h0, 0, 32'h0);
    step("f1", 0, 1, 0, 1, 0, 1, 32'h4, 0, 32'h0);
    step("f2", 0, 1, 0, 1, 1, 0, 32'h8, 0, 32'h0);
    chk("f2 drop_cnt", 32'(dut.drop_cnt), 32'd2);
    chk("f2 count",    32'(dut.count),    32'd0);
    step("f3", 0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0);
    chk("f3 drop_cnt", 32'(dut.drop_cnt), 32'd1);
    step("f4", 0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0);
    chk("f4 drop_cnt", 32'(dut.drop_cnt), 32'd0);
    step("f5", 0, 1, 1, 1, 0, 1, 32'h100, 0, 32'h0);
    step("f6", 0, 1, 1, 1, 0, 1, 32'h104, 0, 32'h0);
    step("f7", 0, 1, 1, 1, 0, 0, 32'h108, 1, 32'h100);

    // 5: flush coincident with a response, one other fetch outstanding
    do_reset("rst_g");
    redirect_pc = 32'h200;
    step("g0", 0, 1, 0, 1, 0, 1, 32'h0, 0, 32'h0);
    step("g1", 0, 1, 0, 1, 0, 1, 32'h4, 0, 32'h0);
    step("g2", 0, 1, 1, 1, 1, 0, 32'h8, 0, 32'h0);
    chk("g2 drop_cnt", 32'(dut.drop_cnt), 32'd1);
    step("g3", 0, 1, 1, 1, 0, 0, 32'h200, 0, 32'h0);
    chk("g3 drop_cnt", 32'(dut.drop_cnt), 32'd0);
    step("g4", 0, 1, 1, 1, 0, 1, 32'h200, 0, 32'h0);
    step("g5", 0, 1, 1, 1, 0, 1, 32'h204, 0, 32'h0);
    step("g6", 0, 1, 1, 1, 0, 0, 32'h208, 1, 32'h200);

    // 6: reset with a full queue (one filled, one in flight)
    do_reset("rst_h");
    step("h0", 0, 1, 1, 0, 0, 1, 32'h0, 0, 32'h0);
    step("h1", 0, 1, 1, 0, 0, 1, 32'h4, 0, 32'h0);
    chk("h1 count", 32'(dut.count), 32'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("h2 imem_req",  32'(imem_req),  32'd0);
    chk("h2 pc_enable", 32'(pc_enable), 32'd0);
    advance();
    chk("h2 count",    32'(dut.count),    32'd0);
    chk("h2 drop_cnt", 32'(dut.drop_cnt), 32'd0);
    step("h3", 0, 0, 1, 1, 0, 1, 32'h0, 0, 32'h0);
    chk("h3 id_pc",    id_pc,    32'd0);
    chk("h3 id_instr", id_instr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
